prefetch: RTL and testbench
===========================

Name: prefetch

Overview:
- Instruction prefetch queue upstream of the cpu fetch stage.
- Issues sequential word reads to the instruction memory bus and buffers {pc, instruction} pairs in a small FIFO.
- Presents the pairs to fetch with a valid/ready handshake.
- Redirects on a taken branch/jump by flushing the queue and restarting at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  synchronous reset, active-low.
- flush_i  input  1  redirect request (driven from control pc_load).
- flush_pc_i  input  32  redirect target address.
- bus_req_o  output  1  bus read request.
- bus_addr_o  output  32  bus read address, word aligned.
- bus_ack_i  input  1  bus completion; bus_data_i is valid in this cycle.
- bus_data_i  input  32  read data.
- valid_o  output  1  pc_o/ir_o hold a valid entry.
- ready_i  input  1  fetch consumes the entry.
- pc_o  output  32  address of the presented instruction.
- ir_o  output  32  presented instruction word.

Behaviour:
- Reset, while rst_ni=0 at a clock edge:
  - FIFO count=0; valid_o=0; bus_req_o=0.
  - bus_addr_o=RESET_PC; state=IDLE; pc_o/ir_o=0.
  - Reset mid-transaction drops bus_req_o immediately; any later ack is ignored.
- Bus protocol:
  - Transfer occurs on a cycle with bus_req_o=1 and bus_ack_i=1. Zero-wait (same-cycle) ack is allowed.
  - While bus_req_o=1 and not acked, bus_addr_o is held stable.
  - Exactly one outstanding request at a time.
- State machine, three states:
  - IDLE: bus_req_o=0. Go to REQ when count<DEPTH.
  - REQ: bus_req_o=1.
    - On ack without flush: push {bus_addr_o, bus_data_i} and set bus_addr_o+=4.
    - After that ack, stay in REQ if (count after this cycle)<DEPTH, otherwise go to IDLE. Back-to-back acks give one instruction per cycle.
  - DISCARD: entered when flush_i=1 while in REQ and not acked in that cycle.
    - bus_req_o stays 1 with the old address.
    - The ack data is dropped; then bus_addr_o=latched target and the block goes to REQ.
- Space reservation:
  - A request is issued only when count<DEPTH, so an acked word always has a slot.
  - Push and pop in the same cycle leave count unchanged.
- Pop: valid_o = (count!=0). An entry is removed on valid_o & ready_i. pc_o/ir_o show the FIFO head.
- Flush (flush_i=1), highest priority:
  - count<=0 and valid_o<=0 next cycle. Any pop or ack data in that cycle is discarded.
  - Target = {flush_pc_i[31:2],2'b00}, with misaligned bits forced to zero.
  - From IDLE, or from REQ acked this cycle: bus_addr_o<=target, state<=REQ, so the request appears the next cycle.
  - From REQ not acked: go to DISCARD, latching the target.
  - Flush while in DISCARD: the latched target is replaced by the new flush_pc_i.
- Arithmetic: address increment is modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000. The FIFO pointers wrap modulo DEPTH.
- Latency, without the bypass feature:
  - Ack cycle N gives valid_o=1 in cycle N+1.
  - After reset release: bus_req_o=1 in the first cycle.

Optional Feature:
- Macro PREFETCH_BYPASS_EN.
- Defined: when count==0 and a transfer occurs with no flush, valid_o=1 in the same cycle, with pc_o=bus_addr_o and ir_o=bus_data_i (combinational path).
  - If ready_i=1 in that cycle, the word is consumed and not written to the FIFO.
  - If ready_i=0, the word is pushed as normal.
- Undefined: no combinational path from bus_data_i/bus_ack_i to the outputs; latency is one cycle as above.

Test Plan:
- Reset then zero-wait bus (ack=1 always), ready_i=1 -> addresses 0,4,8,C on consecutive cycles; valid_o from cycle 2 with pc_o=0,4,8 and ir_o matching memory.
- ready_i=0, DEPTH=4 -> exactly 4 transfers (addr 0..C), then bus_req_o=0 and valid_o held. Raise ready_i for 1 cycle -> pc_o advances to 4 and one new request is issued at addr 10.
- Flush with flush_pc_i=32'h0000_0103 while queue holds 3 entries -> next cycle valid_o=0 and bus_addr_o=32'h0000_0100; first popped entry pc_o=100.
- Bus with 3-cycle ack latency; flush to 32'h200 in the middle of the wait -> request at the old address held until ack, that data never appears on ir_o, next request addr 200.
- Flush with RESET_PC set via flush to 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_o sequence matches.
- Assert rst_ni=0 while bus_req_o=1 unacked, then ack arrives during reset -> no push; after release valid_o=0 and bus_addr_o=RESET_PC.

Source files
------------

// File: rtl/prefetch.sv
// Instruction prefetch queue: sequential word reads into a small {pc, ir} FIFO.
// Optional PREFETCH_BYPASS_EN forwards a fresh bus word straight to fetch when the queue is empty.
module prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   mem_pc [DEPTH];
  logic [31:0]   mem_ir [DEPTH];
  logic [31:0]   tgt_q;
  logic [31:0]   target;
  logic          xfer;
  logic          push;
  logic          pop;
  logic          head_valid;

  assign target     = flush_pc_i & ~32'h3;
  assign bus_req_o  = (state != ST_IDLE);
  assign xfer       = bus_req_o & bus_ack_i;
  assign head_valid = (count != '0);

`ifdef PREFETCH_BYPASS_EN
  logic byp;
  assign byp     = (count == '0) & xfer & (state == ST_REQ) & ~flush_i;
  assign valid_o = head_valid | byp;
  assign pc_o    = byp ? bus_addr_o :
                   (head_valid ? mem_pc[rd_ptr] : '0);
  assign ir_o    = byp ? bus_data_i :
                   (head_valid ? mem_ir[rd_ptr] : '0);
  // A bypassed word taken by fetch never occupies a slot
  assign push    = xfer & (state == ST_REQ) & ~flush_i &
                   ~(byp & ready_i);
`else
  assign valid_o = head_valid;
  assign pc_o    = head_valid ? mem_pc[rd_ptr] : '0;
  assign ir_o    = head_valid ? mem_ir[rd_ptr] : '0;
  assign push    = xfer & (state == ST_REQ) & ~flush_i;
`endif

  assign pop       = head_valid & ready_i & ~flush_i;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      bus_addr_o <= RESET_PC;
      tgt_q      <= RESET_PC;
    end else begin
      if (push) begin
        mem_pc[wr_ptr] <= bus_addr_o;
        mem_ir[wr_ptr] <= bus_data_i;
      end
      if (flush_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (flush_i) begin
            bus_addr_o <= target;
            state      <= ST_REQ;
          end else if (count < FULL) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush_i) begin
            if (bus_ack_i) begin
              bus_addr_o <= target;
            end else begin
              tgt_q <= target;
              state <= ST_DISCARD;
            end
          end else if (bus_ack_i) begin
            bus_addr_o <= bus_addr_o + 32'd4;
            if (count_nxt >= FULL) state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          // The stale read must complete before the new stream starts
          if (flush_i) begin
            if (bus_ack_i) begin
              bus_addr_o <= target;
              state      <= ST_REQ;
            end else begin
              tgt_q <= target;
            end
          end else if (bus_ack_i) begin
            bus_addr_o <= tgt_q;
            state      <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch.sv
// Testbench for prefetch: directed scenarios plus randomized bus/flush traffic
// checked against an instruction-stream model (expected pc sequence and memory image).
module tb_prefetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] ir_o;

  int total = 0;
  int bad = 0;

  int   lat = 1;
  bit   rand_lat = 1'b0;
  logic force_ack = 1'b0;
  logic resp_ack = 1'b0;
  int   wcnt = 0;
  int   cur_lat = 1;

  logic        s_req = 1'b0;
  logic        s_ack = 1'b0;
  logic        s_rst = 1'b0;
  logic [31:0] s_addr = '0;
  logic [31:0] exp_pc = RST_PC;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  assign bus_data_i = mem_word(bus_addr_o);
  assign bus_ack_i  = resp_ack | force_ack;

  prefetch #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .bus_req_o  (bus_req_o),
    .bus_addr_o (bus_addr_o),
    .bus_ack_i  (bus_ack_i),
    .bus_data_i (bus_data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .pc_o       (pc_o),
    .ir_o       (ir_o)
  );

  // Memory responder: ack after cur_lat cycles of a held request
  always @(posedge clk) begin
    #1;
    if (bus_req_o !== 1'b1) begin
      wcnt = 0;
      resp_ack = 1'b0;
    end else begin
      if (s_req && s_ack && s_rst) wcnt = 0;
      if (wcnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 3)) : lat;
      wcnt++;
      resp_ack = (wcnt >= cur_lat);
    end
  end

  // Stream model: fetch must see consecutive words from the current program point
  always @(negedge clk) begin
    if (s_req === 1'b1 && s_ack === 1'b0 && s_rst === 1'b1) begin
      total++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== s_addr) begin
        bad++;
        $display("FAIL bus_hold: req=%b addr=%h, required req=1 addr=%h",
                 bus_req_o, bus_addr_o, s_addr);
      end
    end
    if (rst_ni !== 1'b1) begin
      exp_pc = RST_PC;
    end else begin
      if (valid_o === 1'b1 && ready_i && !flush_i) begin
        total++;
        if (pc_o !== exp_pc || ir_o !== mem_word(exp_pc)) begin
          bad++;
          $display("FAIL stream: pc=%h ir=%h, required pc=%h ir=%h",
                   pc_o, ir_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (flush_i) exp_pc = flush_pc_i & ~32'h3;
    end
    s_req  = bus_req_o;
    s_ack  = bus_ack_i;
    s_rst  = rst_ni;
    s_addr = bus_addr_o;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start(input int l, input logic rdy);
    rst_ni = 1'b0;
    flush_i = 1'b0;
    force_ack = 1'b0;
    rand_lat = 1'b0;
    lat = l;
    ready_i = rdy;
    cyc(2);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    ready_i = 1'b1;
    lat = 1;
    cyc(3);
    total++;
    if (bus_req_o !== 1'b0) begin
      bad++; $display("FAIL reset_req: got %b want 0", bus_req_o);
    end
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    total++;
    if (bus_addr_o !== RST_PC) begin
      bad++; $display("FAIL reset_addr: got %h want %h", bus_addr_o, RST_PC);
    end
    total++;
    if (pc_o !== 32'h0 || ir_o !== 32'h0) begin
      bad++; $display("FAIL reset_out: pc=%h ir=%h want 0 0", pc_o, ir_o);
    end
    rst_ni = 1'b1;
    cyc(1);
    total++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== RST_PC) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h want 1 %h", bus_req_o, bus_addr_o, RST_PC);
    end
  endtask

  task automatic test_stream;
    logic [31:0] ea;
    start(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      ea = 32'(4 * i);
      total++;
      if (bus_addr_o !== ea || !(bus_req_o && bus_ack_i)) begin
        bad++;
        $display("FAIL stream_addr%0d: addr=%h req=%b ack=%b want %h 1 1",
                 i, bus_addr_o, bus_req_o, bus_ack_i, ea);
      end
      total++;
      if (valid_o !== (i > 0)) begin
        bad++; $display("FAIL stream_valid%0d: got %b want %b", i, valid_o, i > 0);
      end
      if (i > 0) begin
        ea = 32'(4 * (i - 1));
        total++;
        if (pc_o !== ea || ir_o !== mem_word(ea)) begin
          bad++;
          $display("FAIL stream_head%0d: pc=%h ir=%h want %h %h",
                   i, pc_o, ir_o, ea, mem_word(ea));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [31:0] a;
    start(1, 1'b0);
    n = 0;
    repeat (8) begin
      cyc(1);
      if (bus_req_o && bus_ack_i) n++;
    end
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL full_xfers: got %0d want 4", n);
    end
    total++;
    if (bus_req_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h0) begin
      bad++;
      $display("FAIL full_hold: req=%b valid=%b pc=%h want 0 1 0", bus_req_o, valid_o, pc_o);
    end
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h4) begin
      bad++; $display("FAIL pop_one: valid=%b pc=%h want 1 4", valid_o, pc_o);
    end
    n = 0;
    a = '0;
    repeat (4) begin
      cyc(1);
      if (bus_req_o && bus_ack_i) begin
        n++;
        a = bus_addr_o;
      end
    end
    total++;
    if (n !== 1 || a !== 32'h10) begin
      bad++; $display("FAIL refill: xfers=%0d addr=%h want 1 10", n, a);
    end
    total++;
    if (bus_req_o !== 1'b0) begin
      bad++; $display("FAIL refill_idle: req=%b want 0", bus_req_o);
    end
  endtask

  task automatic test_flush;
    int k;
    start(1, 1'b0);
    cyc(4);
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
      bad++; $display("FAIL preflush: valid=%b pc=%h want 1 0", valid_o, pc_o);
    end
    flush_i = 1'b1;
    flush_pc_i = 32'h0000_0103;
    cyc(1);
    flush_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || bus_addr_o !== 32'h100 || bus_req_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_next: valid=%b addr=%h req=%b want 0 100 1",
               valid_o, bus_addr_o, bus_req_o);
    end
    ready_i = 1'b1;
    k = 0;
    while (valid_o !== 1'b1 && k < 10) begin
      cyc(1);
      k++;
    end
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h100 || ir_o !== mem_word(32'h100)) begin
      bad++;
      $display("FAIL flush_head: valid=%b pc=%h ir=%h want 1 100 %h",
               valid_o, pc_o, ir_o, mem_word(32'h100));
    end
  endtask

  task automatic test_slow_flush;
    int k;
    int leak;
    start(3, 1'b1);
    cyc(2);
    total++;
    if (bus_req_o !== 1'b1 || bus_ack_i !== 1'b0 || bus_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL slow_wait: req=%b ack=%b addr=%h want 1 0 0",
               bus_req_o, bus_ack_i, bus_addr_o);
    end
    flush_i = 1'b1;
    flush_pc_i = 32'h0000_0200;
    cyc(1);
    flush_i = 1'b0;
    total++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0) begin
      bad++; $display("FAIL discard_hold: req=%b addr=%h want 1 0", bus_req_o, bus_addr_o);
    end
    cyc(1);
    total++;
    if (bus_addr_o !== 32'h200 || valid_o !== 1'b0) begin
      bad++; $display("FAIL discard_next: addr=%h valid=%b want 200 0", bus_addr_o, valid_o);
    end
    k = 0;
    leak = 0;
    while (valid_o !== 1'b1 && k < 10) begin
      cyc(1);
      k++;
    end
    if (valid_o === 1'b1 && ir_o === mem_word(32'h0)) leak++;
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h200 || ir_o !== mem_word(32'h200) || leak != 0) begin
      bad++;
      $display("FAIL discard_head: valid=%b pc=%h ir=%h want 1 200 %h",
               valid_o, pc_o, ir_o, mem_word(32'h200));
    end
  endtask

  task automatic test_wrap;
    logic [31:0] aq[$];
    logic [31:0] pq[$];
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    start(1, 1'b1);
    cyc(2);
    flush_i = 1'b1;
    flush_pc_i = 32'hFFFF_FFF8;
    cyc(1);
    flush_i = 1'b0;
    repeat (6) begin
      if (bus_req_o && bus_ack_i) aq.push_back(bus_addr_o);
      if (valid_o && ready_i) pq.push_back(pc_o);
      cyc(1);
    end
    total++;
    if (aq.size() < 3 || pq.size() < 3) begin
      bad++; $display("FAIL wrap_count: addrs=%0d pcs=%0d want >=3", aq.size(), pq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (aq[i] !== want[i] || pq[i] !== want[i]) begin
          bad++;
          $display("FAIL wrap%0d: addr=%h pc=%h want %h", i, aq[i], pq[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    start(3, 1'b1);
    cyc(1);
    total++;
    if (bus_req_o !== 1'b1 || bus_ack_i !== 1'b0) begin
      bad++; $display("FAIL mid_pre: req=%b ack=%b want 1 0", bus_req_o, bus_ack_i);
    end
    rst_ni = 1'b0;
    force_ack = 1'b1;
    cyc(1);
    total++;
    if (bus_req_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL mid_drop: req=%b valid=%b want 0 0", bus_req_o, valid_o);
    end
    cyc(2);
    force_ack = 1'b0;
    rst_ni = 1'b1;
    cyc(1);
    total++;
    if (valid_o !== 1'b0 || bus_addr_o !== RST_PC || bus_req_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_release: valid=%b addr=%h req=%b want 0 %h 1",
               valid_o, bus_addr_o, bus_req_o, RST_PC);
    end
  endtask

  task automatic test_random;
    int nv;
    start(1, 1'b1);
    rand_lat = 1'b1;
    nv = 0;
    repeat (3000) begin
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 40) == 0);
      flush_pc_i = ($urandom_range(0, 3) == 0) ?
                   32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : $urandom;
      cyc(1);
      if (flush_i) begin
        total++;
        if (valid_o !== 1'b0) begin
          bad++; $display("FAIL rand_flush: valid=%b want 0", valid_o);
        end
      end
      if (valid_o === 1'b1) nv++;
    end
    flush_i = 1'b0;
    ready_i = 1'b1;
    rand_lat = 1'b0;
    cyc(1);
    total++;
    if (nv < 300) begin
      bad++; $display("FAIL rand_progress: valid cycles=%0d want >=300", nv);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_slow_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
